// File: rtl/snake_pkg.sv
// snake_pkg: direction and FSM encodings plus grid defaults
// shared by the snake game-step engine and its body memory.
package snake_pkg;

    typedef enum logic [1:0] {
        DOWN  = 2'b00,
        UP    = 2'b01,
        RIGHT = 2'b10,
        LEFT  = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        CALC,
        SCAN,
        UPDATE,
        DEAD
    } state_e;

    localparam int GRID_W_DEF   = 32;
    localparam int GRID_H_DEF   = 24;
    localparam int MAX_LEN_DEF  = 64;
    localparam int TICK_DIV_DEF = 25000000;
    localparam int START_X_DEF  = 8;
    localparam int START_Y_DEF  = 12;

endpackage

// File: rtl/snake_body_ram.sv
// snake_body_ram: circular body store, one write port and two
// registered read ports; init loads the three starting segments.
module snake_body_ram
    import snake_pkg::*;
#(
    parameter int          DEPTH = MAX_LEN_DEF,
    parameter int          W     = 10,
    parameter logic [W-1:0] INIT0 = '0,
    parameter logic [W-1:0] INIT1 = '0,
    parameter logic [W-1:0] INIT2 = '0,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          init,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic [AW-1:0] sa,
    output logic [W-1:0]  sq,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rq
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (init) begin
            mem[0] <= INIT0;
            mem[1] <= INIT1;
            mem[2] <= INIT2;
        end else if (we) begin
            mem[wa] <= wd;
        end
        sq <= mem[sa];
        rq <= mem[ra];
    end

endmodule

// File: rtl/snake_engine.sv
// snake_engine: tick-driven snake stepper with wrap-around moves,
// sequential self-collision scan, food growth and game-over.
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int MAX_LEN  = MAX_LEN_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int START_X  = START_X_DEF,
    parameter int START_Y  = START_Y_DEF,
    localparam int X_W     = $clog2(GRID_W),
    localparam int Y_W     = $clog2(GRID_H),
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       dir,
    input  logic             start,
    input  logic             pause,
    input  logic [X_W-1:0]   food_x,
    input  logic [Y_W-1:0]   food_y,
    input  logic [LEN_W-2:0] rd_idx,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_valid,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] len,
    output logic             alive,
    output logic             game_over,
    output logic             ate,
    output logic             step
);

    localparam int AW = LEN_W - 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = X_W + Y_W;
    localparam logic [SW-1:0] SEG0 = {X_W'(START_X - 2), Y_W'(START_Y)};
    localparam logic [SW-1:0] SEG1 = {X_W'(START_X - 1), Y_W'(START_Y)};
    localparam logic [SW-1:0] SEG2 = {X_W'(START_X), Y_W'(START_Y)};

    state_e           state, state_nx;
    dir_e             cur_dir;
    logic [CW-1:0]    cnt;
    logic             tick, pending, counting;
    logic             init, match, last, grow;
    logic [X_W-1:0]   hx, nx, mv_x;
    logic [Y_W-1:0]   hy, ny, mv_y;
    logic [AW-1:0]    hd, scan_addr, rd_addr;
    logic [LEN_W-1:0] len_q, scan_i, limit;
    logic [SW-1:0]    scan_seg, rd_seg;

    assign counting  = !(state inside {IDLE, DEAD});
    assign tick      = counting && !pause && (cnt == CW'(TICK_DIV - 1));
    assign limit     = grow ? len_q : len_q - 1'b1;
    assign last      = (scan_i == limit - 1'b1);
    assign match     = (scan_seg == {nx, ny});
    // read is registered, so each SCAN cycle prefetches the next segment
    assign scan_addr = (state == SCAN) ? hd - AW'(scan_i) - 1'b1 : hd;
    assign rd_addr   = hd - rd_idx;

    snake_body_ram #(
        .DEPTH (MAX_LEN),
        .W     (SW),
        .INIT0 (SEG0),
        .INIT1 (SEG1),
        .INIT2 (SEG2)
    ) u_ram (
        .clk  (clk),
        .init (init || !rst),
        .we   (state == UPDATE),
        .wa   (hd + 1'b1),
        .wd   ({nx, ny}),
        .sa   (scan_addr),
        .sq   (scan_seg),
        .ra   (rd_addr),
        .rq   (rd_seg)
    );

    always_comb begin
        mv_x = hx;
        mv_y = hy;
        unique case (1'b1)
            cur_dir == RIGHT: mv_x = (hx == X_W'(GRID_W - 1)) ? '0 : hx + 1'b1;
            cur_dir == LEFT:  mv_x = (hx == '0) ? X_W'(GRID_W - 1) : hx - 1'b1;
            cur_dir == DOWN:  mv_y = (hy == Y_W'(GRID_H - 1)) ? '0 : hy + 1'b1;
            cur_dir == UP:    mv_y = (hy == '0) ? Y_W'(GRID_H - 1) : hy - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        init     = 1'b0;
        unique case (state)
            IDLE, DEAD: begin
                if (start) begin
                    state_nx = WAIT_TICK;
                    init     = 1'b1;
                end
            end
            WAIT_TICK: if (tick || pending) state_nx = CALC;
            CALC:      state_nx = SCAN;
            SCAN: begin
                if (match)     state_nx = DEAD;
                else if (last) state_nx = UPDATE;
            end
            UPDATE:    state_nx = WAIT_TICK;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst || init) begin
            hd      <= AW'(2);
            len_q   <= LEN_W'(3);
            hx      <= X_W'(START_X);
            hy      <= Y_W'(START_Y);
            nx      <= X_W'(START_X);
            ny      <= Y_W'(START_Y);
            grow    <= 1'b0;
            scan_i  <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            cur_dir <= RIGHT;
        end else begin
            if (!counting)   cnt <= '0;
            else if (!pause) cnt <= tick ? '0 : cnt + 1'b1;
            if (state == WAIT_TICK) begin
                if (tick || pending) begin
                    pending <= 1'b0;
                    cur_dir <= dir_e'(dir);
                end
            end else if (tick) begin
                pending <= 1'b1;
            end
            case (state)
                CALC: begin
                    nx     <= mv_x;
                    ny     <= mv_y;
                    grow   <= (mv_x == food_x) && (mv_y == food_y);
                    scan_i <= '0;
                end
                SCAN: scan_i <= scan_i + 1'b1;
                UPDATE: begin
                    hd <= hd + 1'b1;
                    hx <= nx;
                    hy <= ny;
                    if (grow && len_q < LEN_W'(MAX_LEN))
                        len_q <= len_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alive     <= 1'b0;
            game_over <= 1'b0;
            ate       <= 1'b0;
            step      <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            step     <= (state == UPDATE);
            ate      <= (state == UPDATE) && grow;
            rd_valid <= {1'b0, rd_idx} < len_q;
            if (init) begin
                alive     <= 1'b1;
                game_over <= 1'b0;
            end else if (state == SCAN && match) begin
                alive     <= 1'b0;
                game_over <= 1'b1;
            end
        end
    end

    assign rd_x   = rd_seg[SW-1:Y_W];
    assign rd_y   = rd_seg[Y_W-1:0];
    assign head_x = hx;
    assign head_y = hy;
    assign len    = len_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed table of move vectors plus hand-written
// sequences for collision, pause and mid-scan reset.
module tb_snake_engine;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dir = RIGHT;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [4:0] food_x = '0;
    logic [4:0] food_y = '0;
    logic [5:0] rd_idx = '0;
    logic [4:0] rd_x, head_x;
    logic [4:0] rd_y, head_y;
    logic [6:0] len;
    logic       rd_valid, alive, game_over, ate, step;

    snake_engine #(
        .GRID_W   (32),
        .GRID_H   (24),
        .MAX_LEN  (64),
        .TICK_DIV (8),
        .START_X  (8),
        .START_Y  (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dir       (dir),
        .start     (start),
        .pause     (pause),
        .food_x    (food_x),
        .food_y    (food_y),
        .rd_idx    (rd_idx),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_valid  (rd_valid),
        .head_x    (head_x),
        .head_y    (head_y),
        .len       (len),
        .alive     (alive),
        .game_over (game_over),
        .ate       (ate),
        .step      (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] d;
        int fx, fy, n, ex, ey, elen, eate;
    } vec_t;

    vec_t tv [18];
    int   checks = 0;
    int   failures = 0;
    int   nst;
    bit   got, got_ate;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_step(input int budget, output bit g, output bit a);
        g = 1'b0;
        a = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step) begin
                g = 1'b1;
                a = ate;
                break;
            end
        end
        checks++;
        if (!g) begin
            failures++;
            $display("FAIL step_timeout: got no step in %0d cycles, expected one", budget);
        end
    endtask

    task automatic run_vec(input int lo, input int hi);
        int nate;
        bit g, a;
        for (int k = lo; k <= hi; k++) begin
            dir    = tv[k].d;
            food_x = 5'(tv[k].fx);
            food_y = 5'(tv[k].fy);
            nate   = 0;
            for (int s = 0; s < tv[k].n; s++) begin
                wait_step(40, g, a);
                if (a) nate++;
            end
            chk($sformatf("v%0d_head_x", k), head_x, tv[k].ex);
            chk($sformatf("v%0d_head_y", k), head_y, tv[k].ey);
            chk($sformatf("v%0d_len", k), len, tv[k].elen);
            chk($sformatf("v%0d_ate", k), nate, tv[k].eate);
            chk($sformatf("v%0d_game_over", k), game_over, 0);
        end
    endtask

    task automatic rd_chk(input int idx, input int ex, input int ey, input bit ev);
        rd_idx = 6'(idx);
        @(negedge clk);
        chk($sformatf("rd%0d_valid", idx), rd_valid, ev);
        if (ev) begin
            chk($sformatf("rd%0d_x", idx), rd_x, ex);
            chk($sformatf("rd%0d_y", idx), rd_y, ey);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{RIGHT, 0, 0, 3, 11, 12, 3, 0};
        tv[1]  = '{RIGHT, 0, 0, 20, 31, 12, 3, 0};
        tv[2]  = '{UP, 0, 0, 7, 31, 5, 3, 0};
        tv[3]  = '{RIGHT, 0, 0, 1, 0, 5, 3, 0};
        tv[4]  = '{RIGHT, 0, 0, 4, 4, 5, 3, 0};
        tv[5]  = '{UP, 0, 0, 5, 4, 0, 3, 0};
        tv[6]  = '{UP, 0, 0, 1, 4, 23, 3, 0};
        tv[7]  = '{RIGHT, 9, 12, 1, 9, 12, 4, 1};
        tv[8]  = '{RIGHT, 10, 12, 1, 10, 12, 5, 1};
        tv[9]  = '{DOWN, 0, 0, 1, 10, 13, 5, 0};
        tv[10] = '{LEFT, 0, 0, 1, 9, 13, 5, 0};
        tv[11] = '{RIGHT, 9, 12, 1, 9, 12, 4, 1};
        tv[12] = '{DOWN, 0, 0, 1, 9, 13, 4, 0};
        tv[13] = '{LEFT, 0, 0, 1, 8, 13, 4, 0};
        tv[14] = '{UP, 0, 0, 1, 8, 12, 4, 0};
        tv[15] = '{RIGHT, 0, 0, 1, 9, 12, 4, 0};
        tv[16] = '{DOWN, 0, 0, 1, 9, 13, 4, 0};
        tv[17] = '{LEFT, 0, 0, 1, 8, 13, 4, 0};

        repeat (3) @(negedge clk);
        chk("rst_len", len, 3);
        chk("rst_head_x", head_x, 8);
        chk("rst_head_y", head_y, 12);
        chk("rst_alive", alive, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_step", step, 0);
        chk("rst_ate", ate, 0);
        chk("rst_rd_valid", rd_valid, 0);
        rst = 1'b1;
        rd_chk(2, 6, 12, 1'b1);
        rd_chk(0, 8, 12, 1'b1);

        pulse_start();
        chk("start_alive", alive, 1);
        run_vec(0, 0);
        rd_chk(2, 9, 12, 1'b1);
        run_vec(1, 6);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulse_start();
        run_vec(7, 7);
        food_x = 5'd10;
        food_y = 5'd12;
        rd_chk(0, 9, 12, 1'b1);
        rd_chk(1, 8, 12, 1'b1);
        rd_chk(2, 7, 12, 1'b1);
        rd_chk(3, 6, 12, 1'b1);
        rd_chk(4, 0, 0, 1'b0);
        run_vec(8, 10);

        dir = UP;
        nst = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (step) nst++;
            if (game_over) got = 1'b1;
        end
        chk("dead_game_over", game_over, 1);
        chk("dead_alive", alive, 0);
        chk("dead_len", len, 5);
        chk("dead_head_x", head_x, 9);
        chk("dead_head_y", head_y, 13);
        chk("dead_no_step", nst, 0);
        nst = 0;
        repeat (30) begin
            @(negedge clk);
            if (step) nst++;
        end
        chk("dead_frozen_steps", nst, 0);
        rd_chk(0, 9, 13, 1'b1);
        pulse_start();
        chk("restart_len", len, 3);
        chk("restart_head_x", head_x, 8);
        chk("restart_head_y", head_y, 12);
        chk("restart_alive", alive, 1);
        chk("restart_game_over", game_over, 0);

        run_vec(11, 17);

        pause = 1'b1;
        nst = 0;
        repeat (20) begin
            @(negedge clk);
            if (step) nst++;
        end
        chk("pause_no_step", nst, 0);
        chk("pause_head_x", head_x, 8);
        chk("pause_head_y", head_y, 13);
        pause = 1'b0;
        dir = UP;
        wait_step(40, got, got_ate);
        chk("unpause_head_x", head_x, 8);
        chk("unpause_head_y", head_y, 12);
        chk("unpause_len", len, 4);

        // next tick lands 8 cycles after the last one; cycle +5 is mid-SCAN
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("scanrst_len", len, 3);
        chk("scanrst_alive", alive, 0);
        chk("scanrst_step", step, 0);
        chk("scanrst_ate", ate, 0);
        chk("scanrst_head_x", head_x, 8);
        chk("scanrst_head_y", head_y, 12);
        chk("scanrst_rd_valid", rd_valid, 0);
        rst = 1'b1;
        nst = 0;
        repeat (20) begin
            @(negedge clk);
            if (step) nst++;
        end
        chk("idle_no_step", nst, 0);
        chk("idle_alive", alive, 0);
        pulse_start();
        chk("final_alive", alive, 1);
        chk("final_len", len, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
